// File: rtl/sens_pat_gen.sv
// Multi-lane raster pattern generator: h/v timing, blanking flags, selectable
// test patterns and a completed-frame counter, all outputs registered.
//
// state | meaning
// IDLE  | counters parked at 0, idle outputs, waiting for en
// RUN   | raster counters advancing; en/mode/fix_val only sampled at frame end
module sens_pat_gen #(
  parameter int LANES  = 4,
  parameter int PIX_W  = 14,
  parameter int H_ACT  = 480,
  parameter int H_BLK  = 64,
  parameter int V_ACT  = 1080,
  parameter int V_BLK  = 20,
  parameter int CHK_SH = 3
) (
  input  logic                        clk_sens,
  input  logic                        xreset,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic [PIX_W-1:0]            fix_val,
  output logic                        sens_h_start,
  output logic                        sens_v_start,
  output logic                        sens_h_blank,
  output logic                        sens_v_blank,
  output logic [LANES-1:0][PIX_W-1:0] sens_pix_data,
  output logic [15:0]                 frame_cnt
);

  localparam int H_TOT = H_ACT + H_BLK;
  localparam int V_TOT = V_ACT + V_BLK;
  localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
  localparam int HVW   = (HW > VW) ? HW : VW;
  localparam int XW    = (HVW > CHK_SH) ? HVW : CHK_SH + 1;
  localparam int AW    = (PIX_W > 32) ? PIX_W : 32;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_ACT_W = HW'(H_ACT);
  localparam logic [VW-1:0] V_ACT_W = VW'(V_ACT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                       state;
  logic   [HW-1:0]              h_cnt;
  logic   [VW-1:0]              v_cnt;
  logic   [1:0]                 mode_q;
  logic   [PIX_W-1:0]           fix_q;

  logic                         act_h;
  logic                         act_v;
  logic   [XW-1:0]              hv_xor;
  logic                         chk;
  logic   [AW-1:0]              x_val;
  logic   [AW-1:0]              y_val;
  logic   [LANES-1:0][PIX_W-1:0] pix_nxt;

  // Pattern decode from the current counter state; registered below.
  always_comb begin
    act_h   = (h_cnt < H_ACT_W);
    act_v   = (v_cnt < V_ACT_W);
    hv_xor  = XW'(h_cnt) ^ XW'(v_cnt);
    chk     = hv_xor[CHK_SH];
    y_val   = AW'(v_cnt) + AW'(frame_cnt);
    x_val   = '0;
    pix_nxt = '0;
    for (int l = 0; l < LANES; l++) begin
      x_val = AW'(h_cnt) * AW'(LANES) + AW'(l);
      case (mode_q)
        2'd0:    pix_nxt[l] = fix_q;
        2'd1:    pix_nxt[l] = x_val[PIX_W-1:0];
        2'd2:    pix_nxt[l] = y_val[PIX_W-1:0];
        default: pix_nxt[l] = chk ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      endcase
      if (!(act_h && act_v)) pix_nxt[l] = '0;
    end
  end

  always_ff @(posedge clk_sens or negedge xreset) begin
    if (!xreset) begin
      state         <= ST_IDLE;
      h_cnt         <= '0;
      v_cnt         <= '0;
      mode_q        <= 2'd0;
      fix_q         <= '0;
      frame_cnt     <= '0;
      sens_h_start  <= 1'b0;
      sens_v_start  <= 1'b0;
      sens_h_blank  <= 1'b1;
      sens_v_blank  <= 1'b1;
      sens_pix_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          sens_h_start  <= 1'b0;
          sens_v_start  <= 1'b0;
          sens_h_blank  <= 1'b1;
          sens_v_blank  <= 1'b1;
          sens_pix_data <= '0;
          if (en) begin
            state  <= ST_RUN;
            h_cnt  <= '0;
            v_cnt  <= '0;
            mode_q <= mode;
            fix_q  <= fix_val;
          end
        end
        ST_RUN: begin
          sens_h_start  <= (h_cnt == '0) && act_v;
          sens_v_start  <= (h_cnt == '0) && (v_cnt == '0);
          sens_h_blank  <= !act_h;
          sens_v_blank  <= !act_v;
          sens_pix_data <= pix_nxt;
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              // Frame boundary: the only point where en/mode/fix_val matter.
              v_cnt     <= '0;
              frame_cnt <= frame_cnt + 16'd1;
              if (en) begin
                mode_q <= mode;
                fix_q  <= fix_val;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              v_cnt <= v_cnt + VW'(1);
            end
          end else begin
            h_cnt <= h_cnt + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sens_pat_gen.sv
// Directed bench for sens_pat_gen with a 12x5-clock raster (60-clock frame).
module tb_sens_pat_gen;

  localparam int LANES = 4;
  localparam int PIX_W = 14;

  logic                        clk_sens = 1'b0;
  logic                        xreset;
  logic                        en;
  logic [1:0]                  mode;
  logic [PIX_W-1:0]            fix_val;
  logic                        sens_h_start;
  logic                        sens_v_start;
  logic                        sens_h_blank;
  logic                        sens_v_blank;
  logic [LANES-1:0][PIX_W-1:0] sens_pix_data;
  logic [15:0]                 frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sens_pat_gen #(
    .LANES(4), .PIX_W(14), .H_ACT(8), .H_BLK(4), .V_ACT(3), .V_BLK(2), .CHK_SH(3)
  ) dut (
    .clk_sens     (clk_sens),
    .xreset       (xreset),
    .en           (en),
    .mode         (mode),
    .fix_val      (fix_val),
    .sens_h_start (sens_h_start),
    .sens_v_start (sens_v_start),
    .sens_h_blank (sens_h_blank),
    .sens_v_blank (sens_v_blank),
    .sens_pix_data(sens_pix_data),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk_sens = ~clk_sens;

  task automatic step();
    @(posedge clk_sens);
    #1;
  endtask

  // Expected {h_start, v_start, h_blank, v_blank} for frame clock k (0..59).
  function automatic logic [3:0] exp_flags(input int k);
    int h, v;
    h = k % 12;
    v = k / 12;
    return {(h == 0) && (v < 3), k == 0, h >= 8, v >= 3};
  endfunction

  function automatic logic active(input int k);
    return ((k % 12) < 8) && ((k / 12) < 3);
  endfunction

  task automatic test_reset();
    xreset = 1'b0; en = 1'b1; mode = 2'd1; fix_val = '0;
    repeat (3) @(posedge clk_sens);
    #1;
    n_checks++;
    if ({sens_h_start, sens_v_start, sens_h_blank, sens_v_blank} !== 4'b0011 ||
        sens_pix_data !== '0 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_hold flags=%b data=%h fc=%h exp flags=0011 data=0 fc=0",
               {sens_h_start, sens_v_start, sens_h_blank, sens_v_blank}, sens_pix_data, frame_cnt);
    end
    en = 1'b0;
    #2 xreset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      n_checks++;
      if ({sens_h_start, sens_v_start, sens_h_blank, sens_v_blank} !== 4'b0011 ||
          sens_pix_data !== '0 || frame_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL idle_en0 clk=%0d flags=%b data=%h fc=%h exp flags=0011 data=0 fc=0",
                 i, {sens_h_start, sens_v_start, sens_h_blank, sens_v_blank}, sens_pix_data, frame_cnt);
      end
    end
  endtask

  // Two back-to-back mode-1 frames from idle (frame_cnt 0 -> 2).
  task automatic test_geometry();
    logic [LANES-1:0][PIX_W-1:0] ed;
    int nvs, last_vs;
    nvs = 0; last_vs = -1;
    mode = 2'd1; en = 1'b1;
    step();
    for (int i = 0; i < 120; i++) begin
      step();
      ed = '0;
      if (active(i % 60))
        for (int l = 0; l < LANES; l++) ed[l] = PIX_W'((i % 12) * 4 + l);
      n_checks++;
      if ({sens_h_start, sens_v_start, sens_h_blank, sens_v_blank} !== exp_flags(i % 60)) begin
        n_fail++;
        $display("FAIL geom_flags clk=%0d got=%b exp=%b", i,
                 {sens_h_start, sens_v_start, sens_h_blank, sens_v_blank}, exp_flags(i % 60));
      end
      n_checks++;
      if (sens_pix_data !== ed) begin
        n_fail++;
        $display("FAIL geom_data clk=%0d got=%h exp=%h", i, sens_pix_data, ed);
      end
      n_checks++;
      if (frame_cnt !== 16'((i + 1) / 60)) begin
        n_fail++;
        $display("FAIL geom_fcnt clk=%0d got=%0d exp=%0d", i, frame_cnt, (i + 1) / 60);
      end
      if (sens_v_start === 1'b1) begin
        if (last_vs >= 0) begin
          n_checks++;
          if (i - last_vs !== 60) begin
            n_fail++;
            $display("FAIL vstart_period got=%0d exp=60", i - last_vs);
          end
        end
        last_vs = i;
        nvs++;
      end
    end
    n_checks++;
    if (nvs !== 2) begin
      n_fail++;
      $display("FAIL vstart_count got=%0d exp=2", nvs);
    end
  endtask

  // Continues straight on from test_geometry: third frame, en dropped at clock 20.
  task automatic test_enable_drop();
    logic [LANES-1:0][PIX_W-1:0] ed;
    logic [3:0] ef;
    for (int j = 0; j < 120; j++) begin
      step();
      ed = '0;
      ef = 4'b0011;
      if (j < 60) begin
        ef = exp_flags(j);
        if (active(j))
          for (int l = 0; l < LANES; l++) ed[l] = PIX_W'((j % 12) * 4 + l);
      end
      n_checks++;
      if ({sens_h_start, sens_v_start, sens_h_blank, sens_v_blank} !== ef ||
          sens_pix_data !== ed) begin
        n_fail++;
        $display("FAIL drop_out clk=%0d flags=%b exp=%b data=%h exp=%h", j,
                 {sens_h_start, sens_v_start, sens_h_blank, sens_v_blank}, ef, sens_pix_data, ed);
      end
      n_checks++;
      if (frame_cnt !== ((j < 59) ? 16'd2 : 16'd3)) begin
        n_fail++;
        $display("FAIL drop_fcnt clk=%0d got=%0d exp=%0d", j, frame_cnt, (j < 59) ? 2 : 3);
      end
      if (j == 20) en = 1'b0;
    end
  endtask

  task automatic test_mode2_wrap();
    logic [LANES-1:0][PIX_W-1:0] ed;
    logic [15:0] efc;
    int fc;
    force dut.frame_cnt = 16'hFFFF;
    step();
    release dut.frame_cnt;
    step();
    n_checks++;
    if (frame_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_preload got=%h exp=ffff", frame_cnt);
    end
    mode = 2'd2; en = 1'b1;
    step();
    for (int j = 0; j < 120; j++) begin
      step();
      fc = (j < 60) ? 32'hFFFF : 0;
      ed = '0;
      if (active(j % 60))
        for (int l = 0; l < LANES; l++) ed[l] = PIX_W'(((j % 60) / 12 + fc) & 32'h3FFF);
      efc = (j < 59) ? 16'hFFFF : ((j < 119) ? 16'd0 : 16'd1);
      n_checks++;
      if (sens_pix_data !== ed) begin
        n_fail++;
        $display("FAIL wrap_data clk=%0d got=%h exp=%h", j, sens_pix_data, ed);
      end
      n_checks++;
      if (frame_cnt !== efc) begin
        n_fail++;
        $display("FAIL wrap_fcnt clk=%0d got=%h exp=%h", j, frame_cnt, efc);
      end
      if (j == 70) en = 1'b0;
    end
    step();
  endtask

  task automatic test_mode_change();
    logic [LANES-1:0][PIX_W-1:0] ed;
    mode = 2'd0; fix_val = 14'h1234; en = 1'b1;
    step();
    for (int j = 0; j < 120; j++) begin
      step();
      ed = '0;
      // Frame 0 keeps the fixed value; frame 1 is checker, all-zero for h<8, v<3.
      if (j < 60 && active(j))
        for (int l = 0; l < LANES; l++) ed[l] = 14'h1234;
      n_checks++;
      if (sens_pix_data !== ed) begin
        n_fail++;
        $display("FAIL mchg_data clk=%0d got=%h exp=%h", j, sens_pix_data, ed);
      end
      if (j == 30) begin
        mode = 2'd3;
        fix_val = '0;
      end
      if (j == 70) en = 1'b0;
    end
    step();
    n_checks++;
    if (frame_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL mchg_fcnt got=%0d exp=3", frame_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [LANES-1:0][PIX_W-1:0] ed;
    mode = 2'd1; en = 1'b1;
    step();
    repeat (17) step();
    // Counters now at (5,1); outputs show (4,1).
    for (int l = 0; l < LANES; l++) ed[l] = PIX_W'(16 + l);
    n_checks++;
    if (sens_pix_data !== ed || frame_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL rst_pre data=%h exp=%h fc=%0d exp=3", sens_pix_data, ed, frame_cnt);
    end
    #2 xreset = 1'b0;
    #1;
    n_checks++;
    if ({sens_h_start, sens_v_start, sens_h_blank, sens_v_blank} !== 4'b0011 ||
        sens_pix_data !== '0 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_async flags=%b data=%h fc=%h exp flags=0011 data=0 fc=0",
               {sens_h_start, sens_v_start, sens_h_blank, sens_v_blank}, sens_pix_data, frame_cnt);
    end
    step();
    #2 xreset = 1'b1;
    step();
    step();
    for (int l = 0; l < LANES; l++) ed[l] = PIX_W'(l);
    n_checks++;
    if ({sens_h_start, sens_v_start, sens_h_blank, sens_v_blank} !== 4'b1100 ||
        sens_pix_data !== ed || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_restart flags=%b exp=1100 data=%h exp=%h fc=%0d exp=0",
               {sens_h_start, sens_v_start, sens_h_blank, sens_v_blank}, sens_pix_data, ed, frame_cnt);
    end
    en = 1'b0;
    repeat (60) step();
    n_checks++;
    if (frame_cnt !== 16'd1 || sens_v_blank !== 1'b1 || sens_v_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_end fc=%0d exp=1 vb=%b exp=1 vs=%b exp=0", frame_cnt, sens_v_blank, sens_v_start);
    end
  endtask

  initial begin
    test_reset();
    test_geometry();
    test_enable_drop();
    test_mode2_wrap();
    test_mode_change();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
